alu_reservation_station: RTL and testbench

//  Holds dispatched integer ALU ops until both operands are ready, then issues one op per cycle to ALU.

---
 rtl/alu_reservation_station.sv | 170 +++++++++++++++++
 tb/tb_alu_reservation_station.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// Reservation station for the integer ALU: buffers dispatched ops, wakes operands
// from the CDB and issues the lowest-index ready op, one per cycle, through registers.
module alu_reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [3:0]               disp_alu_ctrl,
  input  logic [TAG_W-1:0]         disp_dst_tag,
  input  logic                     disp_s1_rdy,
  input  logic [TAG_W-1:0]         disp_s1_tag,
  input  logic [31:0]              disp_s1_val,
  input  logic                     disp_s2_rdy,
  input  logic [TAG_W-1:0]         disp_s2_tag,
  input  logic [31:0]              disp_s2_val,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [31:0]              cdb_value,
  output logic                     iss_valid,
  output logic [31:0]              iss_A,
  output logic [31:0]              iss_B,
  output logic [3:0]               iss_alu_ctrl,
  output logic [TAG_W-1:0]         iss_dst_tag,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             valid;
    logic [3:0]       ctrl;
    logic [TAG_W-1:0] dstTag;
    logic             s1Rdy;
    logic [TAG_W-1:0] s1Tag;
    logic [31:0]      s1Val;
    logic             s2Rdy;
    logic [TAG_W-1:0] s2Tag;
    logic [31:0]      s2Val;
  } entry_t;

  entry_t entries_q [DEPTH];
  entry_t entries_d [DEPTH];

  logic             issValid_q, issValid_d;
  logic [31:0]      issA_q, issA_d;
  logic [31:0]      issB_q, issB_d;
  logic [3:0]       issCtrl_q, issCtrl_d;
  logic [TAG_W-1:0] issDst_q, issDst_d;

  logic [CNT_W-1:0] occCount;
  logic [IDX_W-1:0] freeIdx;
  logic [IDX_W-1:0] selIdx;
  logic             selFound;
  entry_t           newEntry;

  // Occupancy, lowest free slot and lowest ready slot all come from registered state only,
  // so a slot freed by this cycle's issue is still seen as busy until the next cycle.
  always_comb begin
    occCount = '0;
    freeIdx  = '0;
    selIdx   = '0;
    selFound = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      occCount = occCount + CNT_W'(entries_q[i].valid);
      if (!entries_q[i].valid) begin
        freeIdx = IDX_W'(i);
      end
      if (entries_q[i].valid && entries_q[i].s1Rdy && entries_q[i].s2Rdy) begin
        selIdx   = IDX_W'(i);
        selFound = 1'b1;
      end
    end
  end

  assign disp_ready = (occCount < CNT_W'(DEPTH));

  // A source still waiting at dispatch grabs a same-cycle CDB broadcast so the wakeup is not lost.
  always_comb begin
    newEntry        = '0;
    newEntry.valid  = 1'b1;
    newEntry.ctrl   = disp_alu_ctrl;
    newEntry.dstTag = disp_dst_tag;
    newEntry.s1Rdy  = disp_s1_rdy;
    newEntry.s1Tag  = disp_s1_tag;
    newEntry.s1Val  = disp_s1_val;
    newEntry.s2Rdy  = disp_s2_rdy;
    newEntry.s2Tag  = disp_s2_tag;
    newEntry.s2Val  = disp_s2_val;
    if (cdb_valid && !disp_s1_rdy && (disp_s1_tag == cdb_tag)) begin
      newEntry.s1Rdy = 1'b1;
      newEntry.s1Val = cdb_value;
    end
    if (cdb_valid && !disp_s2_rdy && (disp_s2_tag == cdb_tag)) begin
      newEntry.s2Rdy = 1'b1;
      newEntry.s2Val = cdb_value;
    end
  end

  // Flush wins over everything; otherwise wakeup, issue and dispatch touch disjoint slots.
  always_comb begin
    entries_d  = entries_q;
    issValid_d = 1'b0;
    issA_d     = issA_q;
    issB_d     = issB_q;
    issCtrl_d  = issCtrl_q;
    issDst_d   = issDst_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries_q[i].valid && cdb_valid) begin
          if (!entries_q[i].s1Rdy && (entries_q[i].s1Tag == cdb_tag)) begin
            entries_d[i].s1Rdy = 1'b1;
            entries_d[i].s1Val = cdb_value;
          end
          if (!entries_q[i].s2Rdy && (entries_q[i].s2Tag == cdb_tag)) begin
            entries_d[i].s2Rdy = 1'b1;
            entries_d[i].s2Val = cdb_value;
          end
        end
      end
      if (selFound) begin
        entries_d[selIdx].valid = 1'b0;
        issValid_d = 1'b1;
        issA_d     = entries_q[selIdx].s1Val;
        issB_d     = entries_q[selIdx].s2Val;
        issCtrl_d  = entries_q[selIdx].ctrl;
        issDst_d   = entries_q[selIdx].dstTag;
      end
      if (disp_valid && disp_ready) begin
        entries_d[freeIdx] = newEntry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      issValid_q <= 1'b0;
      issA_q     <= '0;
      issB_q     <= '0;
      issCtrl_q  <= '0;
      issDst_q   <= '0;
    end else begin
      entries_q  <= entries_d;
      issValid_q <= issValid_d;
      issA_q     <= issA_d;
      issB_q     <= issB_d;
      issCtrl_q  <= issCtrl_d;
      issDst_q   <= issDst_d;
    end
  end

  assign iss_valid    = issValid_q;
  assign iss_A        = issA_q;
  assign iss_B        = issB_q;
  assign iss_alu_ctrl = issCtrl_q;
  assign iss_dst_tag  = issDst_q;
  assign occupancy    = occCount;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed, table-driven bench for alu_reservation_station (DEPTH=4, TAG_W=6),
// with hand-written reset sequences at the start and end.
module tb_alu_reservation_station;

  logic        clk = 1'b0;
  logic        reset, flush, disp_valid, disp_ready;
  logic [3:0]  disp_alu_ctrl;
  logic [5:0]  disp_dst_tag, disp_s1_tag, disp_s2_tag, cdb_tag, iss_dst_tag;
  logic        disp_s1_rdy, disp_s2_rdy, cdb_valid, iss_valid;
  logic [31:0] disp_s1_val, disp_s2_val, cdb_value, iss_A, iss_B;
  logic [3:0]  iss_alu_ctrl;
  logic [2:0]  occupancy;

  int numChecks = 0;
  int numFails  = 0;

  alu_reservation_station #(.DEPTH(4), .TAG_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alu_ctrl(disp_alu_ctrl),
    .disp_dst_tag(disp_dst_tag),
    .disp_s1_rdy(disp_s1_rdy), .disp_s1_tag(disp_s1_tag), .disp_s1_val(disp_s1_val),
    .disp_s2_rdy(disp_s2_rdy), .disp_s2_tag(disp_s2_tag), .disp_s2_val(disp_s2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_A(iss_A), .iss_B(iss_B),
    .iss_alu_ctrl(iss_alu_ctrl), .iss_dst_tag(iss_dst_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [3:0]  ctrl;
    logic [5:0]  dst;
    logic        s1r;
    logic [5:0]  s1t;
    logic [31:0] s1v;
    logic        s2r;
    logic [5:0]  s2t;
    logic [31:0] s2v;
    logic        cv;
    logic [5:0]  ct;
    logic [31:0] cval;
    logic        fl;
  } stim_t;

  typedef struct {
    logic        iv;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [5:0]  dst;
    logic [2:0]  occ;
    logic        rdy;
    logic [31:0] res;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t vecs[$];

  function automatic stim_t st(logic dv, logic [3:0] ctrl, logic [5:0] dst,
                               logic s1r, logic [5:0] s1t, logic [31:0] s1v,
                               logic s2r, logic [5:0] s2t, logic [31:0] s2v,
                               logic cv, logic [5:0] ct, logic [31:0] cval, logic fl);
    stim_t s;
    s.dv = dv; s.ctrl = ctrl; s.dst = dst;
    s.s1r = s1r; s.s1t = s1t; s.s1v = s1v;
    s.s2r = s2r; s.s2t = s2t; s.s2v = s2v;
    s.cv = cv; s.ct = ct; s.cval = cval; s.fl = fl;
    return s;
  endfunction

  function automatic exp_t ex(logic iv, logic [31:0] a, logic [31:0] b, logic [3:0] ctrl,
                              logic [5:0] dst, logic [2:0] occ, logic rdy, logic [31:0] res);
    exp_t e;
    e.iv = iv; e.a = a; e.b = b; e.ctrl = ctrl; e.dst = dst;
    e.occ = occ; e.rdy = rdy; e.res = res;
    return e;
  endfunction

  function automatic void add(stim_t s, exp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vecs.push_back(v);
  endfunction

  function automatic logic [31:0] aluModel(logic [3:0] ctrl, logic [31:0] a, logic [31:0] b);
    case (ctrl)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0111: return 32'($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  task automatic applyStimulus(input stim_t s);
    disp_valid    = s.dv;
    disp_alu_ctrl = s.ctrl;
    disp_dst_tag  = s.dst;
    disp_s1_rdy   = s.s1r;
    disp_s1_tag   = s.s1t;
    disp_s1_val   = s.s1v;
    disp_s2_rdy   = s.s2r;
    disp_s2_tag   = s.s2t;
    disp_s2_val   = s.s2v;
    cdb_valid     = s.cv;
    cdb_tag       = s.ct;
    cdb_value     = s.cval;
    flush         = s.fl;
  endtask

  task automatic checkField(input string name, input int step,
                            input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL step %0d %s: got %h, expected %h", step, name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e, input int step);
    checkField("iss_valid", step, 32'(iss_valid), 32'(e.iv));
    checkField("iss_A", step, iss_A, e.a);
    checkField("iss_B", step, iss_B, e.b);
    checkField("iss_alu_ctrl", step, 32'(iss_alu_ctrl), 32'(e.ctrl));
    checkField("iss_dst_tag", step, 32'(iss_dst_tag), 32'(e.dst));
    checkField("occupancy", step, 32'(occupancy), 32'(e.occ));
    checkField("disp_ready", step, 32'(disp_ready), 32'(e.rdy));
    if (e.iv) begin
      checkField("alu_result", step, aluModel(iss_alu_ctrl, iss_A, iss_B), e.res);
    end
  endtask

  initial begin
    stim_t idle;
    idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Add with both sources ready: issues two edges after dispatch, 5+7=12.
    add(st(1, 4'b0010, 1, 1, 0, 5, 1, 0, 7, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 1, 0));
    add(idle, ex(1, 5, 7, 4'b0010, 1, 0, 1, 12));
    add(idle, ex(0, 5, 7, 4'b0010, 1, 0, 1, 0));
    // Sub waiting on tag 3; an invalid CDB with that tag must not wake it.
    add(st(1, 4'b0110, 2, 0, 3, 0, 1, 0, 1, 0, 0, 0, 0), ex(0, 5, 7, 4'b0010, 1, 1, 1, 0));
    add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 99, 0), ex(0, 5, 7, 4'b0010, 1, 1, 1, 0));
    add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 10, 0), ex(0, 5, 7, 4'b0010, 1, 1, 1, 0));
    add(idle, ex(1, 10, 1, 4'b0110, 2, 0, 1, 9));
    add(idle, ex(0, 10, 1, 4'b0110, 2, 0, 1, 0));
    // Same-cycle dispatch and CDB broadcast of tag 9.
    add(st(1, 4'b0111, 3, 0, 9, 32'h123, 1, 0, 4, 1, 9, 32'hFFFF0000, 0),
        ex(0, 10, 1, 4'b0110, 2, 1, 1, 0));
    add(idle, ex(1, 32'hFFFF0000, 4, 4'b0111, 3, 0, 1, 32'hFFFFF000));
    add(idle, ex(0, 32'hFFFF0000, 4, 4'b0111, 3, 0, 1, 0));
    // Fill all four slots with ops waiting on tags 20,21,22,20.
    add(st(1, 4'b0010, 10, 0, 20, 0, 1, 0, 1, 0, 0, 0, 0), ex(0, 32'hFFFF0000, 4, 4'b0111, 3, 1, 1, 0));
    add(st(1, 4'b0010, 11, 0, 21, 0, 1, 0, 2, 0, 0, 0, 0), ex(0, 32'hFFFF0000, 4, 4'b0111, 3, 2, 1, 0));
    add(st(1, 4'b0010, 12, 0, 22, 0, 1, 0, 3, 0, 0, 0, 0), ex(0, 32'hFFFF0000, 4, 4'b0111, 3, 3, 1, 0));
    add(st(1, 4'b0010, 13, 0, 20, 0, 1, 0, 4, 0, 0, 0, 0), ex(0, 32'hFFFF0000, 4, 4'b0111, 3, 4, 0, 0));
    // A ready fifth op while full must vanish.
    add(st(1, 4'b0010, 14, 1, 0, 77, 1, 0, 88, 0, 0, 0, 0), ex(0, 32'hFFFF0000, 4, 4'b0111, 3, 4, 0, 0));
    add(idle, ex(0, 32'hFFFF0000, 4, 4'b0111, 3, 4, 0, 0));
    add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 22, 100, 0), ex(0, 32'hFFFF0000, 4, 4'b0111, 3, 4, 0, 0));
    add(idle, ex(1, 100, 3, 4'b0010, 12, 3, 1, 103));
    // Tag 20 wakes slots 0 and 3 together; slot 0 goes first.
    add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 60, 0), ex(0, 100, 3, 4'b0010, 12, 3, 1, 0));
    add(idle, ex(1, 60, 1, 4'b0010, 10, 2, 1, 61));
    add(idle, ex(1, 60, 4, 4'b0010, 13, 1, 1, 64));
    add(idle, ex(0, 60, 4, 4'b0010, 13, 1, 1, 0));
    // Three valid, then flush with a concurrent ready dispatch.
    add(st(1, 4'b0001, 15, 0, 30, 0, 1, 0, 5, 0, 0, 0, 0), ex(0, 60, 4, 4'b0010, 13, 2, 1, 0));
    add(st(1, 4'b0001, 16, 0, 31, 0, 1, 0, 6, 0, 0, 0, 0), ex(0, 60, 4, 4'b0010, 13, 3, 1, 0));
    add(st(1, 4'b0010, 17, 1, 0, 1, 1, 0, 2, 0, 0, 0, 1), ex(0, 60, 4, 4'b0010, 13, 0, 1, 0));
    add(idle, ex(0, 60, 4, 4'b0010, 13, 0, 1, 0));
    // Flush suppresses an issue that was about to happen.
    add(st(1, 4'b0010, 18, 1, 0, 3, 1, 0, 4, 0, 0, 0, 0), ex(0, 60, 4, 4'b0010, 13, 1, 1, 0));
    add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(0, 60, 4, 4'b0010, 13, 0, 1, 0));
    add(idle, ex(0, 60, 4, 4'b0010, 13, 0, 1, 0));
    // Undefined ctrl passes through; dispatch and issue in one cycle; s2 wakeup.
    add(st(1, 4'b1111, 5, 1, 0, 8, 1, 0, 9, 0, 0, 0, 0), ex(0, 60, 4, 4'b0010, 13, 1, 1, 0));
    add(st(1, 4'b0011, 6, 1, 0, 32'hF0, 0, 40, 0, 0, 0, 0, 0), ex(1, 8, 9, 4'b1111, 5, 1, 1, 0));
    add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 40, 32'hFF, 0), ex(0, 8, 9, 4'b1111, 5, 1, 1, 0));
    add(idle, ex(1, 32'hF0, 32'hFF, 4'b0011, 6, 0, 1, 32'h0F));
    add(idle, ex(0, 32'hF0, 32'hFF, 4'b0011, 6, 0, 1, 0));

    // Reset held with a dispatch attempt: nothing recorded, outputs zero.
    reset = 1'b1;
    applyStimulus(st(1, 4'b0010, 1, 1, 0, 5, 1, 0, 7, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput(ex(0, 0, 0, 0, 0, 0, 1, 0), -1);
    reset = 1'b0;
    applyStimulus(idle);
    @(posedge clk);
    #1;
    checkOutput(ex(0, 0, 0, 0, 0, 0, 1, 0), -2);

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].s);
      @(posedge clk);
      #1;
      checkOutput(vecs[k].e, k);
    end

    // Reset mid-run, while a ready op is selectable, clears issue registers too.
    applyStimulus(st(1, 4'b0010, 7, 1, 0, 2, 1, 0, 3, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput(ex(0, 32'hF0, 32'hFF, 4'b0011, 6, 1, 1, 0), 1000);
    applyStimulus(idle);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput(ex(0, 0, 0, 0, 0, 0, 1, 0), 1001);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(ex(0, 0, 0, 0, 0, 0, 1, 0), 1002);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
